// File: rtl/alu_div_unit.sv
// Iterative RV32M divide/remainder unit: 32-step radix-2 restoring division with
// RISC-V sign rules and divide-by-zero / signed-overflow special cases.
module alu_div_unit #(
  parameter int unsigned data_width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            div_op,
  input  logic [data_width-1:0] operand_A,
  input  logic [data_width-1:0] operand_B,
  input  logic                  flush,
  output logic [data_width-1:0] div_result,
  output logic                  done,
  output logic                  hold_pipeline
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  localparam logic [data_width-1:0] IntMin = {1'b1, {(data_width-1){1'b0}}};

  state_e                state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [1:0]            op_q, op_d;
  logic                  a_neg_q, a_neg_d;
  logic                  b_neg_q, b_neg_d;
  logic [data_width-1:0] rem_q, rem_d;
  logic [data_width-1:0] quo_q, quo_d;
  logic [data_width-1:0] dvs_q, dvs_d;
  logic [data_width-1:0] result_q, result_d;
  logic                  hold;

  // Shifted partial remainder and trial difference; bit 32 of diff is the borrow.
  logic [data_width:0]   rem_sh;
  logic [data_width:0]   diff;
  logic                  in_signed;

  assign in_signed = ~div_op[0];
  assign rem_sh    = {rem_q, quo_q[data_width-1]};
  assign diff      = rem_sh - {1'b0, dvs_q};

  // Next-state, datapath and stall request.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    hold     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          hold    = 1'b1;
          op_d    = div_op;
          a_neg_d = in_signed & operand_A[data_width-1];
          b_neg_d = in_signed & operand_B[data_width-1];
          if (operand_B == '0) begin
            result_d = div_op[1] ? operand_A : '1;
            state_d  = StDone;
          end else if (in_signed && operand_A == IntMin && operand_B == '1) begin
            result_d = div_op[1] ? '0 : IntMin;
            state_d  = StDone;
          end else begin
            rem_d   = '0;
            quo_d   = a_neg_d ? -operand_A : operand_A;
            dvs_d   = b_neg_d ? -operand_B : operand_B;
            cnt_d   = '0;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        hold = 1'b1;
        if (!diff[data_width]) begin
          rem_d = diff[data_width-1:0];
          quo_d = {quo_q[data_width-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[data_width-1:0];
          quo_d = {quo_q[data_width-2:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StFix;
      end
      StFix: begin
        hold = 1'b1;
        if (op_q[1]) result_d = a_neg_q ? -rem_q : rem_q;
        else         result_d = (a_neg_q ^ b_neg_q) ? -quo_q : quo_q;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A killed instruction never updates the visible result.
    if (flush) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
    end
  end

  assign div_result    = result_q;
  assign done          = (state_q == StDone);
  assign hold_pipeline = hold & ~rst;

endmodule

// File: tb/tb_alu_div_unit.sv
// Directed bench for alu_div_unit with a scoreboard queue of expected results.
module tb_alu_div_unit;

  localparam logic [1:0] OpDiv  = 2'b00;
  localparam logic [1:0] OpDivu = 2'b01;
  localparam logic [1:0] OpRem  = 2'b10;
  localparam logic [1:0] OpRemu = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  div_op;
  logic [31:0] operand_A;
  logic [31:0] operand_B;
  logic        flush;
  logic [31:0] div_result;
  logic        done;
  logic        hold_pipeline;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] sb[$];
  logic [31:0] last_res;

  alu_div_unit #(.data_width(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .div_op       (div_op),
    .operand_A    (operand_A),
    .operand_B    (operand_B),
    .flush        (flush),
    .div_result   (div_result),
    .done         (done),
    .hold_pipeline(hold_pipeline)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation and follow it to its done pulse.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int          cyc;
    int          hold_n;
    bit          seen;
    logic [31:0] exp_v;
    @(negedge clk);
    start = 1'b1; div_op = op; operand_A = a; operand_B = b;
    sb.push_back(exp);
    cyc = 0; hold_n = 0; seen = 1'b0;
    while (!seen && cyc < 60) begin
      #1;
      if (hold_pipeline) hold_n++;
      if (done) begin
        seen  = 1'b1;
        exp_v = sb.pop_front();
        check({tag, "_result"}, div_result, exp_v);
        check({tag, "_latency"}, 32'(cyc), 32'(lat));
      end
      @(negedge clk);
      // Operands wander after the latch; the unit must ignore them.
      start = 1'b0; operand_A = $urandom; operand_B = $urandom; div_op = 2'($urandom);
      cyc++;
    end
    check({tag, "_seen_done"}, 32'(seen), 32'd1);
    if (!seen) void'(sb.pop_front());
    #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_hold_cycles"}, 32'(hold_n), 32'(lat));
    last_res = exp;
  endtask

  initial begin
    int hold_n;
    int done_n;
    rst = 1'b1; start = 1'b0; flush = 1'b0; div_op = '0; operand_A = '0; operand_B = '0;
    last_res = '0;
    #1;
    check("rst_result", div_result, 32'h0);
    check("rst_done", 32'(done), 32'd0);
    start = 1'b1;
    #1;
    check("rst_hold", 32'(hold_pipeline), 32'd0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("div_m7_2",   OpDiv,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
    run_op("rem_m7_2",   OpRem,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
    run_op("divu_big",   OpDivu, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 34);
    run_op("remu_big",   OpRemu, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 34);
    run_op("div_7_m2",   OpDiv,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    run_op("rem_7_m2",   OpRem,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 34);
    run_op("div_5_0",    OpDiv,  32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run_op("rem_5_0",    OpRem,  32'd5,         32'd0,         32'h0000_0005, 1);
    run_op("remu_min_0", OpRemu, 32'h8000_0000, 32'd0,         32'h8000_0000, 1);
    run_op("div_ovf",    OpDiv,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",    OpRem,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    run_op("divu_noovf", OpDivu, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34);
    run_op("div_100_7a", OpDiv,  32'd100,       32'd7,         32'd14,        34);

    // Flush during CALC: start a fresh 200/7 so a stale result would differ.
    @(negedge clk);
    start = 1'b1; div_op = OpDiv; operand_A = 32'd200; operand_B = 32'd7;
    sb.push_back(32'd28);
    hold_n = 0; done_n = 0;
    for (int c = 0; c <= 10; c++) begin
      if (c == 10) flush = 1'b1;
      #1;
      if (hold_pipeline) hold_n++;
      if (done) done_n++;
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b0;
    #1;
    void'(sb.pop_front());
    check("flush_hold_after", 32'(hold_pipeline), 32'd0);
    check("flush_done_after", 32'(done), 32'd0);
    check("flush_result_kept", div_result, last_res);
    check("flush_hold_cycles", 32'(hold_n), 32'd11);
    check("flush_no_done", 32'(done_n), 32'd0);
    repeat (3) begin
      @(negedge clk); #1;
      check("flush_stays_idle", 32'(done), 32'd0);
    end
    run_op("div_100_7b", OpDiv, 32'd100, 32'd7, 32'd14, 34);

    // Asynchronous reset in the middle of a DIVU.
    run_op("divu_prime", OpDivu, 32'd1000, 32'd3, 32'd333, 34);
    @(negedge clk);
    start = 1'b1; div_op = OpDivu; operand_A = 32'hFFFF_FFFF; operand_B = 32'd3;
    sb.push_back(32'h5555_5555);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    check("pre_rst_hold", 32'(hold_pipeline), 32'd1);
    rst = 1'b1;
    #1;
    void'(sb.pop_front());
    check("rst_mid_hold", 32'(hold_pipeline), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_result", div_result, 32'h0);
    last_res = '0;
    @(negedge clk);
    rst = 1'b0;
    run_op("remu_after_rst", OpRemu, 32'h1234_5678, 32'h100, 32'h0000_0078, 34);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_div_unit.md
# alu_div_unit

Iterative RV32M divide/remainder engine for the EX stage, beside the ALU. It latches the operands and the decoded divide opcode, runs a 32-step radix-2 restoring division, and applies the RISC-V sign and corner-case rules. It returns a 32-bit result into the EX result mux and drives `hold_pipeline` to stall IF/ID/EX while the division is in flight.

## Interface
- `data_width`, 32, operand and result width; only 32 is supported.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  a divide-class instruction is in EX; sampled only in IDLE.
- `div_op`  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `operand_A`  in  data_width  dividend, signed-typed; interpretation is set by `div_op`.
- `operand_B`  in  data_width  divisor, same typing.
- `flush`  in  1  synchronous kill from branch/exception logic.
- `div_result`  out  data_width  quotient or remainder; registered and held until overwritten.
- `done`  out  1  one-cycle pulse marking `div_result` valid for the current instruction.
- `hold_pipeline`  out  1  stall request to the pipeline control.

## Operation
- States:
  - IDLE
  - CALC: 32 iterations, with a 5-bit iteration counter.
  - FIX: sign correction and select.
  - DONE: one cycle.
- IDLE transitions:
  - `start` and not `flush` latches `operand_A`, `operand_B` and `div_op`.
  - A divisor of 0, or a signed DIV/REM of 0x80000000 by 0xFFFFFFFF, is a special case: go to DONE with the special result loaded.
  - Otherwise load |A| and |B| (the magnitudes when the op is signed, the raw values when unsigned), clear the remainder and counter, and go to CALC.
- CALC: each edge shifts {rem,quo} left by 1 and trial-subtracts the divisor from the 33-bit remainder.
  - Non-negative difference: keep it and set quotient LSB = 1.
  - Negative difference: restore and set quotient LSB = 0.
  - After the iteration with counter = 31, go to FIX.
- FIX:
  - Quotient is negated when the op is signed and the operand signs differ.
  - Remainder takes the sign of the dividend.
  - DIV/DIVU write the quotient to `div_result`; REM/REMU write the remainder.
  - Go to DONE.
- DONE: assert `done` and go to IDLE. `start` is ignored in this cycle, because the same instruction is still in EX.
- Special-case results:
  - Divide by 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give `operand_A`.
  - Signed overflow: DIV gives 0x80000000; REM gives 0.
- Operand changes after the latch are ignored.
- `flush`:
  - In any state it forces IDLE on the next edge.
  - `done` is not pulsed and `div_result` is unchanged.
  - `flush` and `start` together in IDLE: `flush` wins and nothing is latched.
- `hold_pipeline` is combinational: (IDLE & `start` & ~`flush`) | CALC | FIX. It is 0 in DONE and whenever `rst` is high.
- Reset values: state IDLE, `div_result` 0, `done` 0, counter 0, `hold_pipeline` 0.

## Timing
- Cycle 0 is the cycle in which `start` is high in IDLE.
- Normal operation:
  - Cycles 1–32: CALC.
  - Cycle 33: FIX.
  - Cycle 34: DONE, with `done`=1 and `div_result` valid.
  - `hold_pipeline` is high in cycles 0–33 (34 cycles).
- Special cases:
  - Cycle 1: DONE.
  - `hold_pipeline` is high in cycle 0 only.
- Back-to-back: a new `start` is accepted in the cycle after DONE, which is IDLE.
- Reset asserted mid-operation: outputs go to their reset values immediately, with no clock required. After release, the first `start` is processed normally.
- Throughput: one divide per 35 cycles in the normal case.

## Test plan
- DIV, A=-7 (0xFFFFFFF9), B=2 -> `div_result` 0xFFFFFFFD at cycle 34. `hold_pipeline` is high for exactly 34 cycles and `done` for 1. The same operands with REM -> 0xFFFFFFFF.
- DIVU, A=0xFFFFFFFF, B=0x10 -> 0x0FFFFFFF. REMU with the same operands -> 0x0000000F.
- DIV 5/0 -> 0xFFFFFFFF at cycle 1. REM 5/0 -> 0x00000005. REMU 0x80000000/0 -> 0x80000000.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at cycle 1. REM with the same operands -> 0.
- DIV 100/7 -> 14; assert `flush` at cycle 10 -> IDLE at cycle 11, no `done` pulse, `div_result` keeps its old value, `hold_pipeline` goes to 0. A following DIV 100/7 -> 14, and the restarted operation takes the full 34 cycles.
- Assert `rst` at cycle 20 of a DIVU -> `hold_pipeline`, `done` and `div_result` are 0 immediately. After release, REMU 0x12345678/0x100 -> 0x78.
